// File: rtl/id_pkg.sv
// Shared constants for the decode/register-read stage: branch condition
// codes and the instruction word used for pipeline bubbles.
package id_pkg;

    localparam logic [2:0] CMP_NONE = 3'd0;
    localparam logic [2:0] CMP_EQ   = 3'd1;
    localparam logic [2:0] CMP_NE   = 3'd2;
    localparam logic [2:0] CMP_LEZ  = 3'd3;
    localparam logic [2:0] CMP_GTZ  = 3'd4;
    localparam logic [2:0] CMP_LTZ  = 3'd5;
    localparam logic [2:0] CMP_GEZ  = 3'd6;

    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/id_fwd_mux.sv
// Operand resolution for one read port: zero register, then the youngest
// matching forward source, then same-cycle write-through, then the array.
module id_fwd_mux #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NFWD     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]        addr,
    input  logic [NFWD-1:0]      fwd_en,
    input  logic [NFWD*AW-1:0]   fwd_addr,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    input  logic [XLEN-1:0]      rf_data,
    output logic [XLEN-1:0]      data
);

    // Lowest priority assigned first; later assignments override, so the
    // forward loop runs from oldest to youngest and source 0 wins.
    always_comb begin
        data = rf_data;
        if (wr_en && wr_addr == addr)
            data = wr_data;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (fwd_en[k] && fwd_addr[k*AW +: AW] == addr)
                data = fwd_data[k*XLEN +: XLEN];
        end
        if (ZERO_REG != 0 && addr == '0)
            data = '0;
    end

endmodule

// File: rtl/id_regread_stage.sv
// Decode/register-read stage: register file, forwarded operands, branch
// decision and the D/E pipeline register with hold and bubble controls.
module id_regread_stage
    import id_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NFWD     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_pc,
    input  logic [AW-1:0]        rs_addr,
    input  logic [AW-1:0]        rt_addr,
    input  logic [AW-1:0]        dst_addr,
    input  logic [15:0]          imm16,
    input  logic                 ext_sign,
    input  logic [2:0]           cmp_op,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    input  logic [NFWD-1:0]      fwd_en,
    input  logic [NFWD*AW-1:0]   fwd_addr,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 hold,
    input  logic                 stall,
    input  logic                 flush,
    output logic [XLEN-1:0]      rd1,
    output logic [XLEN-1:0]      rd2,
    output logic                 branch_taken,
    output logic                 e_valid,
    output logic [XLEN-1:0]      e_rd1,
    output logic [XLEN-1:0]      e_rd2,
    output logic [31:0]          e_instr,
    output logic [AW-1:0]        e_wra,
    output logic [XLEN-1:0]      e_ext,
    output logic [31:0]          e_pc
);

    logic [XLEN-1:0] rf [NREG];
    logic [XLEN-1:0] rf_rs, rf_rt;
    logic [XLEN-1:0] ext;
    logic            wr_ok;
    logic            cond;

    assign wr_ok = wr_en && (int'(wr_addr) < NREG) && !(ZERO_REG != 0 && wr_addr == '0);

    // Register file write; reset clears every entry and beats the write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else if (wr_ok) begin
            rf[wr_addr] <= wr_data;
        end
    end

    // Array read; addresses beyond the implemented registers read as zero.
    always_comb begin
        rf_rs = '0;
        rf_rt = '0;
        if (int'(rs_addr) < NREG) rf_rs = rf[rs_addr];
        if (int'(rt_addr) < NREG) rf_rt = rf[rt_addr];
    end

    id_fwd_mux #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD), .ZERO_REG(ZERO_REG)) u_fwd_rs (
        .addr(rs_addr), .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rf_data(rf_rs), .data(rd1)
    );

    id_fwd_mux #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD), .ZERO_REG(ZERO_REG)) u_fwd_rt (
        .addr(rt_addr), .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rf_data(rf_rt), .data(rd2)
    );

    // Branch condition on resolved operands; rd1 compares against zero signed.
    always_comb begin
        cond = 1'b0;
        case (cmp_op)
            CMP_EQ:  cond = (rd1 == rd2);
            CMP_NE:  cond = (rd1 != rd2);
            CMP_LEZ: cond = ($signed(rd1) <= 0);
            CMP_GTZ: cond = ($signed(rd1) > 0);
            CMP_LTZ: cond = rd1[XLEN-1];
            CMP_GEZ: cond = !rd1[XLEN-1];
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken = in_valid && cond && !stall;
    assign ext = {{(XLEN-16){ext_sign & imm16[15]}}, imm16};

    // D/E register: reset, then hold, then bubble, then load.
    always_ff @(posedge clk) begin
        if (reset || (!hold && (stall || flush || !in_valid))) begin
            e_valid <= 1'b0;
            e_rd1   <= '0;
            e_rd2   <= '0;
            e_instr <= NOP_INSTR;
            e_wra   <= '0;
            e_ext   <= '0;
            e_pc    <= '0;
        end else if (!hold) begin
            e_valid <= 1'b1;
            e_rd1   <= rd1;
            e_rd2   <= rd2;
            e_instr <= in_instr;
            e_wra   <= dst_addr;
            e_ext   <= ext;
            e_pc    <= in_pc;
        end
    end

endmodule
